// File: rtl/rca_digit_serial_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rca_pkg
// Brief    : Shared state encoding and sizing helpers for rca_digit_serial.
// Revision : 1.0
// ============================================================================
package rca_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Digit counter never needs less than one bit, even when NDIG == 1.
    function automatic int cnt_width(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rca_digit_serial_if.sv
`default_nettype none
// ============================================================================
// Module   : rca_digit_serial_if
// Brief    : Operand/result valid-ready bundle; ovf present with RCA_OVF_FLAG_EN.
// Revision : 1.0
// ============================================================================
interface rca_digit_serial_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
`ifdef RCA_OVF_FLAG_EN
    logic             ovf;

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, busy, ovf
    );
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, busy, ovf
    );
`else
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );
`endif
endinterface
`default_nettype wire

// File: rtl/rca_digit.sv
`default_nettype none
// ============================================================================
// Module   : rca_digit
// Brief    : W-bit combinational ripple chain; c_msb_in only with RCA_OVF_FLAG_EN.
// Revision : 1.0
// ============================================================================
module rca_digit #(
    parameter int W = 8
) (
    input  wire logic [W-1:0] a,
    input  wire logic [W-1:0] b,
    input  wire logic         cin,
    output logic      [W-1:0] sum,
`ifdef RCA_OVF_FLAG_EN
    output logic              c_msb_in,
`endif
    output logic              cout
);
    logic [W:0] w_c;

    assign w_c[0] = cin;

    generate
        for (genvar i = 0; i < W; i++) begin : g_fa
            assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
            assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
        end
    endgenerate

    assign cout = w_c[W];
`ifdef RCA_OVF_FLAG_EN
    assign c_msb_in = w_c[W-1];
`endif
endmodule
`default_nettype wire

// File: rtl/rca_digit_serial.sv
`default_nettype none
// ============================================================================
// Module   : rca_digit_serial
// Brief    : Digit-serial ripple-carry add/sub, LSB digit first. Option: RCA_OVF_FLAG_EN.
// Revision : 1.0
// ============================================================================
module rca_digit_serial
    import rca_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    rca_digit_serial_if.slave  bus
);
    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = cnt_width(NDIG);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [DIGIT-1:0]   w_d;
    logic               w_c;
    logic               w_last;
    logic [WIDTH-1:0]   w_a_shr;
    logic [WIDTH-1:0]   w_b_shr;
    logic [WIDTH-1:0]   w_sum_nxt;

    assign w_last = (r_cnt == CNT_W'(NDIG - 1));

`ifdef RCA_OVF_FLAG_EN
    logic w_cmsb;
    logic r_ovf;

    rca_digit #(.W(DIGIT)) u_digit (
        .a        (r_a[DIGIT-1:0]),
        .b        (r_b[DIGIT-1:0]),
        .cin      (r_carry),
        .sum      (w_d),
        .c_msb_in (w_cmsb),
        .cout     (w_c)
    );
`else
    rca_digit #(.W(DIGIT)) u_digit (
        .a        (r_a[DIGIT-1:0]),
        .b        (r_b[DIGIT-1:0]),
        .cin      (r_carry),
        .sum      (w_d),
        .cout     (w_c)
    );
`endif

    // New digits enter the result from the top so the first one ends at bit 0.
    generate
        if (DIGIT == WIDTH) begin : g_single
            assign w_a_shr   = '0;
            assign w_b_shr   = '0;
            assign w_sum_nxt = w_d;
        end else begin : g_multi
            assign w_a_shr   = {{DIGIT{1'b0}}, r_a[WIDTH-1:DIGIT]};
            assign w_b_shr   = {{DIGIT{1'b0}}, r_b[WIDTH-1:DIGIT]};
            assign w_sum_nxt = {w_d, r_sum[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.in_valid)  w_state_nxt = ST_BUSY;
            ST_BUSY: if (w_last)        w_state_nxt = ST_DONE;
            ST_DONE: if (bus.out_ready) w_state_nxt = ST_IDLE;
            default:                    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
`ifdef RCA_OVF_FLAG_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_a     <= bus.a;
                        r_b     <= bus.sub ? ~bus.b : bus.b;
                        r_carry <= bus.sub ? ~bus.cin : bus.cin;
                        r_cnt   <= '0;
                    end
                end
                ST_BUSY: begin
                    r_a     <= w_a_shr;
                    r_b     <= w_b_shr;
                    r_sum   <= w_sum_nxt;
                    r_carry <= w_c;
                    r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
`ifdef RCA_OVF_FLAG_EN
                    if (w_last) r_ovf <= w_cmsb ^ w_c;
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.busy      = (r_state == ST_BUSY);
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.sum       = r_sum;
    assign bus.cout      = r_carry;
`ifdef RCA_OVF_FLAG_EN
    assign bus.ovf       = r_ovf;
`endif
endmodule
`default_nettype wire
